zigbee_tx_frame: RTL and testbench
==================================

Name: zigbee_tx_frame

Overview:
- Builds and serialises one XBee API-mode-1 Transmit Request frame (frame type 0x10) carrying a 2-byte motor payload (velocity, directions).
- It is the outbound counterpart of the RX-packet (0x90) frame parser.
- Sits between the control logic and the UART transmitter. Presents one byte at a time on a valid/ready byte interface and computes the trailing checksum on the fly.
- No byte escaping; the radio runs in API mode 1.

Parameters:
- BCAST_RADIUS, 8'h00, broadcast-radius byte inserted in the frame (0 = network max hops).
- TX_OPTIONS, 8'h00, transmit-options byte inserted in the frame.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle request to send a frame; sampled only in IDLE.
- frame_id  input  8  API frame ID (0 = no TX status requested).
- dest_addr64  input  64  destination 64-bit address, sent MSB byte first.
- dest_addr16  input  16  destination 16-bit network address, sent MSB byte first (0xFFFE = unknown).
- ve  input  8  payload byte 0 (velocity).
- dirs  input  8  payload byte 1 (direction bits).
- tx_data  output  8  current frame byte to the UART.
- tx_valid  output  1  tx_data is valid; held until accepted.
- tx_ready  input  1  UART can accept a byte; transfer occurs on a cycle with tx_valid && tx_ready.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the checksum byte is transferred.

Behaviour:
- Reset (reset=0, async): state=IDLE, tx_data=8'h00, tx_valid=0, busy=0, done=0, index=0, checksum accumulator=0, captured fields=0.
- IDLE with start=1:
  - Capture frame_id, dest_addr64, dest_addr16, ve, dirs into internal registers.
  - Next cycle: busy=1, tx_valid=1, tx_data=0x7E.
  - Inputs may change after the start cycle without affecting the frame.
- start while busy: ignored; no queuing.
- Frame byte order (20 bytes total):
  - 0x7E, 0x00, 0x10 (length = 16).
  - Then 0x10, frame_id.
  - Then addr64[63:56] … addr64[7:0], addr16[15:8], addr16[7:0].
  - Then BCAST_RADIUS, TX_OPTIONS, ve, dirs, checksum.
- States:
  - IDLE.
  - DELIM (0x7E).
  - LEN_MSB.
  - LEN_LSB.
  - API: 4-bit index 0..15 selects the API byte.
  - CKSUM.
  - DONE.
- Transitions:
  - Each state advances only on a cycle where tx_valid && tx_ready.
  - API increments index per transfer and exits to CKSUM after index 15 transfers.
- Checksum:
  - 8-bit accumulator, cleared on start.
  - Adds each API byte (index 0..15) mod 256 on its transfer.
  - Checksum byte = 8'hFF − accumulator. Delimiter and length bytes are excluded.
- Holding rules:
  - tx_data and tx_valid must be stable while tx_valid=1 and tx_ready=0; no byte skipped or repeated.
  - Back-to-back transfers allowed: with tx_ready held high, one byte per cycle. Full frame = 20 transfer cycles + 1 start cycle.
- After the checksum transfer:
  - Go to DONE: tx_valid=0, done=1 for exactly one cycle.
  - Then IDLE with busy=0.
  - A start on the DONE cycle is ignored; one is accepted on the first IDLE cycle.
- tx_valid is never high in IDLE or DONE.
- Reset mid-frame: immediate abort. Outputs return to reset values and no further bytes are presented; the partial frame is discarded by the receiver via checksum.
- Index wrap: index is a 4-bit counter; it wraps 15→0 only on exit to CKSUM and is cleared on start.

Test Plan:
- Reset sequencing: reset=0 for 3 cycles, then 1 → tx_valid=0, busy=0, done=0; start absent → outputs remain idle for 50 cycles.
- Minimal frame, tx_ready tied 1: all inputs 0, params default, start pulse → bytes exactly 7E 00 10 10 00 00×8 00 00 00 00 00 00 EF. Then done pulses once, cycle after last byte.
- Typical frame:
  - Inputs: frame_id=01, dest_addr64=0x0013A20040A1B2C3, dest_addr16=0xFFFE, ve=55, dirs=0A, tx_ready=1.
  - Required bytes: 7E 00 10 10 01 00 13 A2 00 40 A1 B2 C3 FF FE 00 00 55 0A 87.
- Backpressure: same typical frame with tx_ready random (~30% high) → identical 20-byte sequence; tx_data stable whenever tx_valid && !tx_ready; no duplicates.
- start during busy: pulse start again at byte 5 with different ve → current frame unchanged, no second frame, busy low after done.
- Reset mid-frame: assert reset at byte 10 → tx_valid=0 immediately. After release, a new start produces a complete correct frame beginning with 7E.

Source files
------------

// File: rtl/zigbee_tx_frame.sv
// XBee API-mode-1 Transmit Request (0x10) framer for a 2-byte motor payload.
// Presents one byte per valid/ready handshake and appends the running checksum.
module zigbee_tx_frame #(
  parameter logic [7:0] BCAST_RADIUS = 8'h00,
  parameter logic [7:0] TX_OPTIONS   = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  frame_id,
  input  logic [63:0] dest_addr64,
  input  logic [15:0] dest_addr16,
  input  logic [7:0]  ve,
  input  logic [7:0]  dirs,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  // state   | meaning
  // IDLE    | waiting for start
  // DELIM   | presenting 0x7E
  // LEN_MSB | presenting length MSB (0x00)
  // LEN_LSB | presenting length LSB (0x10)
  // API     | presenting API byte r_index (0..15)
  // CKSUM   | presenting checksum byte
  // DONE    | one-cycle done pulse, tx_valid low
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DELIM   = 3'd1,
    LEN_MSB = 3'd2,
    LEN_LSB = 3'd3,
    API     = 3'd4,
    CKSUM   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t      r_state;
  logic [3:0]  r_index;
  logic [7:0]  r_cksum;
  logic [7:0]  r_frame_id;
  logic [63:0] r_addr64;
  logic [15:0] r_addr16;
  logic [7:0]  r_ve;
  logic [7:0]  r_dirs;

  logic        w_xfer;
  logic [3:0]  w_sel_index;
  logic [7:0]  w_api_byte;
  logic [7:0]  w_cksum_sum;

  assign w_xfer      = tx_valid && tx_ready;
  assign w_cksum_sum = r_cksum + tx_data;

  // In LEN_LSB the next byte is API byte 0; in API it is the following index.
  assign w_sel_index = (r_state == API) ? (r_index + 4'd1) : 4'd0;

  always_comb begin
    w_api_byte = 8'h00;
    case (w_sel_index)
      4'd0:  w_api_byte = 8'h10;
      4'd1:  w_api_byte = r_frame_id;
      4'd2:  w_api_byte = r_addr64[63:56];
      4'd3:  w_api_byte = r_addr64[55:48];
      4'd4:  w_api_byte = r_addr64[47:40];
      4'd5:  w_api_byte = r_addr64[39:32];
      4'd6:  w_api_byte = r_addr64[31:24];
      4'd7:  w_api_byte = r_addr64[23:16];
      4'd8:  w_api_byte = r_addr64[15:8];
      4'd9:  w_api_byte = r_addr64[7:0];
      4'd10: w_api_byte = r_addr16[15:8];
      4'd11: w_api_byte = r_addr16[7:0];
      4'd12: w_api_byte = BCAST_RADIUS;
      4'd13: w_api_byte = TX_OPTIONS;
      4'd14: w_api_byte = r_ve;
      4'd15: w_api_byte = r_dirs;
      default: w_api_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_index    <= 4'd0;
      r_cksum    <= 8'h00;
      r_frame_id <= 8'h00;
      r_addr64   <= 64'h0;
      r_addr16   <= 16'h0;
      r_ve       <= 8'h00;
      r_dirs     <= 8'h00;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_frame_id <= frame_id;
            r_addr64   <= dest_addr64;
            r_addr16   <= dest_addr16;
            r_ve       <= ve;
            r_dirs     <= dirs;
            r_index    <= 4'd0;
            r_cksum    <= 8'h00;
            tx_data    <= 8'h7E;
            tx_valid   <= 1'b1;
            busy       <= 1'b1;
            r_state    <= DELIM;
          end
        end
        DELIM: begin
          if (w_xfer) begin
            tx_data <= 8'h00;
            r_state <= LEN_MSB;
          end
        end
        LEN_MSB: begin
          if (w_xfer) begin
            tx_data <= 8'h10;
            r_state <= LEN_LSB;
          end
        end
        LEN_LSB: begin
          if (w_xfer) begin
            tx_data <= w_api_byte;
            r_index <= 4'd0;
            r_state <= API;
          end
        end
        API: begin
          if (w_xfer) begin
            r_cksum <= w_cksum_sum;
            if (r_index == 4'd15) begin
              r_index <= 4'd0;
              tx_data <= 8'hFF - w_cksum_sum;
              r_state <= CKSUM;
            end else begin
              r_index <= r_index + 4'd1;
              tx_data <= w_api_byte;
            end
          end
        end
        CKSUM: begin
          if (w_xfer) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            done     <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigbee_tx_frame.sv
// Directed bench for zigbee_tx_frame: reset, minimal/typical frames,
// backpressure, start while busy and reset mid-frame.
module tb_zigbee_tx_frame;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  frame_id;
  logic [63:0] dest_addr64;
  logic [15:0] dest_addr16;
  logic [7:0]  ve;
  logic [7:0]  dirs;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got [20];
  int         n_got;
  logic       aborted;

  logic [7:0] exp_min [20] = '{8'h7E, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'hEF};
  logic [7:0] exp_typ [20] = '{8'h7E, 8'h00, 8'h10, 8'h10, 8'h01, 8'h00, 8'h13, 8'hA2,
                               8'h00, 8'h40, 8'hA1, 8'hB2, 8'hC3, 8'hFF, 8'hFE, 8'h00,
                               8'h00, 8'h55, 8'h0A, 8'h87};

  zigbee_tx_frame dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .frame_id    (frame_id),
    .dest_addr64 (dest_addr64),
    .dest_addr16 (dest_addr16),
    .ve          (ve),
    .dirs        (dirs),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; pulses start and scrambles inputs afterwards.
  task automatic pulse_start(input logic [7:0] fid, input logic [63:0] a64,
                             input logic [15:0] a16, input logic [7:0] v, input logic [7:0] d);
    frame_id = fid; dest_addr64 = a64; dest_addr16 = a16; ve = v; dirs = d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    frame_id = 8'hA5; dest_addr64 = 64'hDEAD_BEEF_0BAD_F00D; dest_addr16 = 16'h1234;
    ve = 8'h77; dirs = 8'h33;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Collects up to 20 transferred bytes; optionally re-pulses start or resets.
  task automatic collect(input int pct, input int start_at, input int reset_at);
    logic       hold;
    logic [7:0] held;
    logic       rdy;
    logic       pulsed;
    hold = 1'b0; held = 8'h00; pulsed = 1'b0;
    n_got = 0; aborted = 1'b0;
    for (int c = 0; c < 3000 && n_got < 20; c++) begin
      if (reset_at >= 0 && n_got == reset_at) begin
        reset = 1'b0;
        #1;
        check("abort_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        aborted = 1'b1;
        break;
      end
      if (start_at >= 0 && n_got == start_at && !pulsed) begin
        start = 1'b1; ve = 8'h99; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      rdy = ($urandom_range(0, 99) < pct);
      tx_ready = rdy;
      if (hold) begin
        check("hold_valid", {63'd0, tx_valid}, 64'd1);
        check("hold_data", {56'd0, tx_data}, {56'd0, held});
      end
      if (tx_valid && rdy) begin
        got[n_got] = tx_data;
        n_got++;
        hold = 1'b0;
      end else if (tx_valid) begin
        hold = 1'b1;
        held = tx_data;
      end else begin
        hold = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    if (!aborted) check("frame_byte_count", 64'(n_got), 64'd20);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] expv [20]);
    for (int i = 0; i < 20; i++)
      check($sformatf("%s_b%0d", tag, i), {56'd0, got[i]}, {56'd0, expv[i]});
  endtask

  // Called at the negedge right after collect() of a full frame.
  task automatic check_done_tail(input string tag);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd1);
    check({tag, "_done_valid"}, {63'd0, tx_valid}, 64'd0);
    @(negedge clock);
    check({tag, "_done_low"}, {63'd0, done}, 64'd0);
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic seen;
    reset = 1'b0; start = 1'b0; tx_ready = 1'b0;
    frame_id = 8'h00; dest_addr64 = 64'h0; dest_addr16 = 16'h0; ve = 8'h00; dirs = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    reset = 1'b1;
    tx_ready = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clock);
      seen = seen | tx_valid | busy | done;
    end
    check("idle_50_cycles", {63'd0, seen}, 64'd0);

    // Minimal frame, plus a start on the DONE cycle that must be ignored.
    pulse_start(8'h00, 64'h0, 16'h0, 8'h00, 8'h00);
    collect(100, -1, -1);
    check_bytes("min", exp_min);
    check("min_done_pulse", {63'd0, done}, 64'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("min_done_low", {63'd0, done}, 64'd0);
    check("min_idle_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      seen = seen | tx_valid | busy;
    end
    check("start_on_done_ignored", {63'd0, seen}, 64'd0);

    // Typical frame, tx_ready tied high.
    pulse_start(8'h01, 64'h0013_A200_40A1_B2C3, 16'hFFFE, 8'h55, 8'h0A);
    collect(100, -1, -1);
    check_bytes("typ", exp_typ);
    check_done_tail("typ");

    // Backpressure: ~30% ready.
    pulse_start(8'h01, 64'h0013_A200_40A1_B2C3, 16'hFFFE, 8'h55, 8'h0A);
    collect(30, -1, -1);
    check_bytes("bp", exp_typ);
    check_done_tail("bp");

    // start while busy at byte 5 with a different ve.
    pulse_start(8'h01, 64'h0013_A200_40A1_B2C3, 16'hFFFE, 8'h55, 8'h0A);
    collect(100, 5, -1);
    check_bytes("busy_start", exp_typ);
    check_done_tail("busy_start");
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      seen = seen | tx_valid | busy;
    end
    check("no_second_frame", {63'd0, seen}, 64'd0);

    // Reset mid-frame at byte 10, then a clean frame.
    pulse_start(8'h01, 64'h0013_A200_40A1_B2C3, 16'hFFFE, 8'h55, 8'h0A);
    collect(100, -1, 10);
    @(negedge clock);
    check("rst_mid_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_data", {56'd0, tx_data}, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_idle", {63'd0, tx_valid}, 64'd0);
    pulse_start(8'h01, 64'h0013_A200_40A1_B2C3, 16'hFFFE, 8'h55, 8'h0A);
    collect(100, -1, -1);
    check_bytes("post_rst", exp_typ);
    check_done_tail("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
